// File: rtl/signature_dot_pkg.sv
// Shared types, constants and elaboration helpers for the signature dot-product stage.
package signature_dot_pkg;

    localparam int unsigned COMP_WIDTH_DEF = 8;
    localparam int unsigned COEF_WIDTH_DEF = 16;
    localparam int unsigned MAX_BANDS_DEF  = 256;
    localparam int unsigned ACC_WIDTH_DEF  = 32;
    localparam int unsigned OUT_WIDTH_DEF  = 8;
    localparam int unsigned OUT_SHIFT_DEF  = 8;

    // Ceiling log2, used for address widths at elaboration time
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // Signed coefficient times zero-extended component needs one extra bit
    function automatic int unsigned prod_width(input int unsigned coef_w, input int unsigned comp_w);
        return coef_w + comp_w + 1;
    endfunction

    localparam int unsigned PROD_WIDTH = prod_width(COEF_WIDTH_DEF, COMP_WIDTH_DEF);

    typedef logic signed [COEF_WIDTH_DEF-1:0] coef_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/sig_coef_ram.sv
// Target-signature coefficient store: synchronous write, asynchronous read.
// Contents have no reset so a stage reset keeps the loaded signature.
module sig_coef_ram
    import signature_dot_pkg::*;
#(
    parameter int unsigned C_DEPTH = MAX_BANDS_DEF,
    parameter int unsigned C_WIDTH = COEF_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [clog2(C_DEPTH)-1:0]    wr_addr,
    input  logic [C_WIDTH-1:0]           wr_data,
    input  logic [clog2(C_DEPTH)-1:0]    rd_addr,
    output logic [C_WIDTH-1:0]           rd_data
);

    logic [C_WIDTH-1:0] mem [C_DEPTH];

    // Coefficient write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/signature_dot_stage.sv
// Streaming matched filter: dots each band-interleaved pixel vector with the
// loaded signature and emits one scaled score per pixel.
// Build option: SIGNATURE_DOT_SATURATE_EN saturates the shifted accumulator to
// the signed output range; otherwise the low output bits are kept.
module signature_dot_stage
    import signature_dot_pkg::*;
#(
    parameter int unsigned C_COMP_WIDTH = COMP_WIDTH_DEF,
    parameter int unsigned C_COEF_WIDTH = COEF_WIDTH_DEF,
    parameter int unsigned C_MAX_BANDS  = MAX_BANDS_DEF,
    parameter int unsigned C_ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int unsigned C_OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int unsigned C_OUT_SHIFT  = OUT_SHIFT_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [C_COMP_WIDTH-1:0]           s_axis_tdata,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_OUT_WIDTH-1:0]            m_axis_tdata,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic                              coef_wr_en,
    input  logic [clog2(C_MAX_BANDS)-1:0]     coef_wr_addr,
    input  logic [C_COEF_WIDTH-1:0]           coef_wr_data,
    input  logic [7:0]                        cfg_num_bands,
    output logic                              busy,
    output logic                              err_early_last
);

    localparam int unsigned AW = clog2(C_MAX_BANDS);
    localparam int unsigned PW = prod_width(C_COEF_WIDTH, C_COMP_WIDTH);

`ifdef SIGNATURE_DOT_SATURATE_EN
    localparam logic signed [C_ACC_WIDTH-1:0] SAT_MAX =
        {{(C_ACC_WIDTH-C_OUT_WIDTH+1){1'b0}}, {(C_OUT_WIDTH-1){1'b1}}};
    localparam logic signed [C_ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

    state_t                         state;
    logic [AW-1:0]                  band_cnt;
    logic [AW-1:0]                  last_idx_q;
    logic signed [C_ACC_WIDTH-1:0]  acc;
    logic signed [C_COEF_WIDTH-1:0] coef_rd;

    logic [AW-1:0]                  cfg_last_idx_c;
    logic [AW-1:0]                  last_idx_c;
    logic                           first_c;
    logic                           end_c;
    logic                           early_c;
    logic                           beat_c;
    logic                           drain_c;
    logic                           busy_nx_c;
    logic signed [PW-1:0]           prod_c;
    logic signed [C_ACC_WIDTH-1:0]  acc_sum_c;
    logic [C_OUT_WIDTH-1:0]         score_c;
`ifdef SIGNATURE_DOT_SATURATE_EN
    logic signed [C_ACC_WIDTH-1:0]  shifted_c;
`endif

    sig_coef_ram #(
        .C_DEPTH (C_MAX_BANDS),
        .C_WIDTH (C_COEF_WIDTH)
    ) u_coef_ram (
        .clk     (clk),
        .wr_en   (coef_wr_en),
        .wr_addr (coef_wr_addr),
        .wr_data (coef_wr_data),
        .rd_addr (band_cnt),
        .rd_data (coef_rd)
    );

    // Beat qualification, pixel-end detection, multiply-accumulate and scaling
    always_comb begin
        cfg_last_idx_c = (cfg_num_bands == 8'd0) ? AW'(C_MAX_BANDS - 1)
                                                 : AW'(cfg_num_bands - 8'd1);
        first_c    = (state == ST_IDLE);
        last_idx_c = first_c ? cfg_last_idx_c : last_idx_q;
        end_c      = (band_cnt == last_idx_c) || s_axis_tlast;
        early_c    = s_axis_tlast && (band_cnt != last_idx_c);

        // Stall only the beat that would need a full, blocked output register
        s_axis_tready = !reset && !(m_axis_tvalid && !m_axis_tready && end_c);
        beat_c        = s_axis_tvalid && s_axis_tready;
        drain_c       = m_axis_tvalid && m_axis_tready;

        prod_c    = PW'(coef_rd) * PW'($signed({1'b0, s_axis_tdata}));
        acc_sum_c = first_c ? C_ACC_WIDTH'(prod_c) : (acc + C_ACC_WIDTH'(prod_c));

`ifdef SIGNATURE_DOT_SATURATE_EN
        shifted_c = acc_sum_c >>> C_OUT_SHIFT;
        if (shifted_c > SAT_MAX) begin
            score_c = C_OUT_WIDTH'(SAT_MAX);
        end else if (shifted_c < SAT_MIN) begin
            score_c = C_OUT_WIDTH'(SAT_MIN);
        end else begin
            score_c = C_OUT_WIDTH'(shifted_c);
        end
`else
        score_c = acc_sum_c[C_OUT_SHIFT +: C_OUT_WIDTH];
`endif

        busy_nx_c = (beat_c ? !end_c : (state == ST_ACCUM))
                 || (beat_c && end_c)
                 || (m_axis_tvalid && !m_axis_tready);
    end

    // Pixel FSM, band counter, accumulator, output register and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            band_cnt       <= '0;
            last_idx_q     <= '0;
            acc            <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tdata   <= '0;
            m_axis_tlast   <= 1'b0;
            busy           <= 1'b0;
            err_early_last <= 1'b0;
        end else begin
            if (beat_c) begin
                acc <= acc_sum_c;
                if (first_c) begin
                    last_idx_q <= cfg_last_idx_c;
                end
                if (end_c) begin
                    state    <= ST_IDLE;
                    band_cnt <= '0;
                end else begin
                    state    <= ST_ACCUM;
                    band_cnt <= band_cnt + AW'(1);
                end
                if (early_c) begin
                    err_early_last <= 1'b1;
                end
            end

            if (beat_c && end_c) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= score_c;
                m_axis_tlast  <= s_axis_tlast;
            end else if (drain_c) begin
                m_axis_tvalid <= 1'b0;
            end

            busy <= busy_nx_c;
        end
    end

endmodule

// File: tb/tb_signature_dot_stage.sv
// Directed bench for signature_dot_stage with a queue-based output scoreboard.
module tb_signature_dot_stage;
    import signature_dot_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        coef_wr_en;
    logic [7:0]  coef_wr_addr;
    logic [15:0] coef_wr_data;
    logic [7:0]  cfg_num_bands;
    logic        busy;
    logic        err_early_last;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } score_t;

    score_t exp_q[$];
    int     checks    = 0;
    int     failures  = 0;
    int     n_pushed  = 0;
    int     n_rcvd    = 0;
    int     pix_idx   = 0;
    logic   bp_en     = 1'b0;

    signature_dot_stage dut (
        .clk            (clk),
        .reset          (reset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .coef_wr_en     (coef_wr_en),
        .coef_wr_addr   (coef_wr_addr),
        .coef_wr_data   (coef_wr_data),
        .cfg_num_bands  (cfg_num_bands),
        .busy           (busy),
        .err_early_last (err_early_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int nb_eff();
        return (cfg_num_bands == 8'd0) ? 256 : int'(cfg_num_bands);
    endfunction

    task automatic push_exp(input logic [7:0] data, input logic last);
        score_t s;
        s.data = data;
        s.last = last;
        exp_q.push_back(s);
        n_pushed++;
    endtask

    task automatic wr_coef(input int addr, input logic [15:0] value);
        coef_wr_en   = 1'b1;
        coef_wr_addr = 8'(addr);
        coef_wr_data = value;
        @(posedge clk);
        #1;
        coef_wr_en   = 1'b0;
    endtask

    // Present one beat until accepted; called and returns at posedge+1
    task automatic send_beat(input logic [7:0] data, input logic last);
        int   waited;
        logic taken;
        waited = 0;
        taken  = 1'b0;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        while (!taken && waited < 200) begin
            @(negedge clk);
            taken = s_axis_tready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (taken) begin
            if (last || pix_idx == nb_eff() - 1) pix_idx = 0;
            else pix_idx++;
        end else begin
            check("send_timeout", 32'(taken), 32'd1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 2000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Output-side backpressure: toggles every 3 clocks when enabled
    initial begin
        int cnt;
        cnt = 0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                cnt++;
                if (cnt == 3) begin
                    cnt = 0;
                    m_axis_tready = !m_axis_tready;
                end
            end else begin
                cnt = 0;
                m_axis_tready = 1'b1;
            end
        end
    end

    // Scoreboard monitor and input-stall legality check
    initial begin
        score_t s;
        logic   end_exp;
        forever begin
            @(negedge clk);
            if (!reset && m_axis_tvalid && m_axis_tready) begin
                n_rcvd++;
                if (exp_q.size() == 0) begin
                    check("unexpected_score", 32'(m_axis_tdata), 32'hFFFF_FFFF);
                end else begin
                    s = exp_q.pop_front();
                    check("score_data", 32'(m_axis_tdata), 32'(s.data));
                    check("score_last", 32'(m_axis_tlast), 32'(s.last));
                end
            end
            if (!reset && s_axis_tvalid) begin
                end_exp = (pix_idx == nb_eff() - 1) || s_axis_tlast;
                check("s_tready", 32'(s_axis_tready),
                      32'(!(m_axis_tvalid && !m_axis_tready && end_exp)));
            end
        end
    end

    initial begin
        logic [7:0] bp_a [6];
        logic [7:0] bp_b [6];
        bp_a = '{8'd5, 8'd17, 8'd99, 8'd127, 8'd64, 8'd33};
        bp_b = '{8'd7, 8'd200, 8'd1, 8'd255, 8'd0, 8'd33};

        reset         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        coef_wr_en    = 1'b0;
        coef_wr_addr  = '0;
        coef_wr_data  = '0;
        cfg_num_bands = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err_early_last), 32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        reset = 1'b0;

        // Basic pixel: 10*1+20*2+30*3+40*4 = 300, >>>8 = 1
        wr_coef(0, 16'd1);
        wr_coef(1, 16'd2);
        wr_coef(2, 16'd3);
        wr_coef(3, 16'd4);
        cfg_num_bands = 8'd4;
        check("idle_tready", 32'(s_axis_tready), 32'd1);
        send_beat(8'd10, 1'b0);
        send_beat(8'd20, 1'b0);
        send_beat(8'd30, 1'b0);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_no_valid_yet", 32'(m_axis_tvalid), 32'd0);
        push_exp(8'd1, 1'b0);
        send_beat(8'd40, 1'b0);
        check("basic_latency_valid", 32'(m_axis_tvalid), 32'd1);
        wait_drain("basic_drain");
        repeat (2) @(posedge clk);
        #1;
        check("basic_idle_busy", 32'(busy), 32'd0);

        // Negative: 2 * (-32768*255) = -16711680, >>>8 = -65280
        wr_coef(0, 16'h8000);
        wr_coef(1, 16'h8000);
        cfg_num_bands = 8'd2;
`ifdef SIGNATURE_DOT_SATURATE_EN
        push_exp(8'h80, 1'b0);
`else
        push_exp(8'h00, 1'b0);
`endif
        send_beat(8'd255, 1'b0);
        send_beat(8'd255, 1'b0);
        wait_drain("neg_drain");

        // Backpressure: coef {256,1} makes each score equal to the first beat
        wr_coef(0, 16'd256);
        wr_coef(1, 16'd1);
        cfg_num_bands = 8'd2;
        bp_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_exp(bp_a[i], (i == 5));
            send_beat(bp_a[i], 1'b0);
            send_beat(bp_b[i], (i == 5));
        end
        wait_drain("bp_drain");
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("bp_err_clear", 32'(err_early_last), 32'd0);

        // Early tlast: 200*100 + 100*(-30) + 50*50 = 19500, >>>8 = 76
        wr_coef(0, 16'd100);
        wr_coef(1, 16'hFFE2);
        wr_coef(2, 16'd50);
        cfg_num_bands = 8'd10;
        push_exp(8'd76, 1'b1);
        send_beat(8'd200, 1'b0);
        send_beat(8'd100, 1'b0);
        send_beat(8'd50, 1'b1);
        check("early_err_set", 32'(err_early_last), 32'd1);
        wait_drain("early_drain");
        repeat (5) @(posedge clk);
        #1;
        check("early_err_sticky", 32'(err_early_last), 32'd1);
        check("early_busy_done", 32'(busy), 32'd0);

        // nb=0 means 256 bands: 256 ones times coef 1, >>>8 = 1
        for (int i = 0; i < 256; i++) wr_coef(i, 16'd1);
        cfg_num_bands = 8'd0;
        for (int i = 0; i < 255; i++) send_beat(8'd1, 1'b0);
        check("nb0_no_valid_yet", 32'(m_axis_tvalid), 32'd0);
        push_exp(8'd1, 1'b0);
        send_beat(8'd1, 1'b0);
        check("nb0_valid", 32'(m_axis_tvalid), 32'd1);
        wait_drain("nb0_drain");

        // Reset mid-pixel: the partial pixel vanishes, coefficients survive
        wr_coef(0, 16'd256);
        wr_coef(1, 16'd512);
        wr_coef(2, 16'd768);
        wr_coef(3, 16'd1024);
        cfg_num_bands = 8'd4;
        send_beat(8'd9, 1'b0);
        send_beat(8'd9, 1'b0);
        check("rmid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        pix_idx = 0;
        check("rmid_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rmid_busy_clr", 32'(busy), 32'd0);
        check("rmid_err_clr", 32'(err_early_last), 32'd0);
        // 1*256 + 2*512 + 3*768 + 4*1024 = 7680, >>>8 = 30
        push_exp(8'd30, 1'b0);
        send_beat(8'd1, 1'b0);
        send_beat(8'd2, 1'b0);
        send_beat(8'd3, 1'b0);
        send_beat(8'd4, 1'b0);
        wait_drain("rmid_drain");

        repeat (4) @(posedge clk);
        #1;
        check("score_count", 32'(n_rcvd), 32'(n_pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
